// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes and helpers for the register front-end.
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clog2(input int v);
        for (int r = 0; r < 32; r++)
            if ((1 << r) >= v) return r;
        return 32;
    endfunction

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                               input logic [63:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction
endpackage

// File: rtl/axil_reg_bank_if.sv
// axil_reg_bank_if: AXI4-Lite bus bundle between interconnect master and register slave.
interface axil_reg_bank_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_wr_capture.sv
// axil_wr_capture: independent AW/W holding registers merged into one write-fire strobe.
module axil_wr_capture #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    input  logic                bvalid,
    output logic                fire,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W-1:0]   data,
    output logic [DATA_W/8-1:0] strb
);
    logic                aw_full, w_full, aw_hs, w_hs;
    logic [ADDR_W-1:0]   aw_q;
    logic [DATA_W-1:0]   w_q;
    logic [DATA_W/8-1:0] s_q;

    assign awready = rst_n && !aw_full && !bvalid;
    assign wready  = rst_n && !w_full && !bvalid;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    // the later of the two halves fires the write on its own handshake edge
    assign fire    = (aw_full || aw_hs) && (w_full || w_hs);
    assign addr    = aw_full ? aw_q : awaddr;
    assign data    = w_full ? w_q : wdata;
    assign strb    = w_full ? s_q : wstrb;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_q    <= '0;
            w_q     <= '0;
            s_q     <= '0;
        end else begin
            aw_full <= (aw_full || aw_hs) && !fire;
            w_full  <= (w_full || w_hs) && !fire;
            if (aw_hs) aw_q <= awaddr;
            if (w_hs) begin
                w_q <= wdata;
                s_q <= wstrb;
            end
        end
endmodule

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: parametrised AXI4-Lite slave with NUM_RW control and NUM_RO status registers.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int NUM_RW = 4,
    parameter int NUM_RO = 2,
    parameter logic [DATA_W-1:0] RW_RESET = '0,
    localparam int NUM_ST = NUM_RO > 0 ? NUM_RO : 1
) (
    input  logic                       S_AXI_ACLK,
    input  logic                       S_AXI_ARESETN,
    axil_reg_bank_if.slave             s_axi,
    output logic [NUM_RW*DATA_W-1:0]   ctrl_q,
    output logic [NUM_RW-1:0]          ctrl_wr_pulse,
    input  logic [NUM_ST*DATA_W-1:0]   status_d,
    output logic [NUM_ST-1:0]          status_rd_pulse
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = clog2(STRB_W);

    logic              wr_fire, unused_bits;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data, wr_mask, rd_val;
    logic [STRB_W-1:0] wr_strb;
    int                wr_idx, rd_idx;

    axil_wr_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_capture (
        .clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN),
        .awaddr(s_axi.awaddr), .awvalid(s_axi.awvalid), .awready(s_axi.awready),
        .wdata(s_axi.wdata), .wstrb(s_axi.wstrb), .wvalid(s_axi.wvalid), .wready(s_axi.wready),
        .bvalid(s_axi.bvalid), .fire(wr_fire), .addr(wr_addr), .data(wr_data), .strb(wr_strb)
    );

    assign wr_idx         = int'(wr_addr[ADDR_W-1:ADDR_LSB]);
    assign rd_idx         = int'(s_axi.araddr[ADDR_W-1:ADDR_LSB]);
    assign s_axi.arready  = S_AXI_ARESETN && !s_axi.rvalid;
    assign unused_bits    = ^{s_axi.awprot, s_axi.arprot, wr_addr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

    always_comb begin
        wr_mask = '0;
        for (int k = 0; k < STRB_W; k++) wr_mask[k*8 +: 8] = {8{wr_strb[k]}};
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_RW; i++) if (rd_idx == i) rd_val = ctrl_q[i*DATA_W +: DATA_W];
        for (int i = 0; i < NUM_RO; i++) if (rd_idx == NUM_RW + i) rd_val = status_d[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            ctrl_q        <= {NUM_RW{RW_RESET}};
            ctrl_wr_pulse <= '0;
            s_axi.bvalid  <= 1'b0;
            s_axi.bresp   <= RESP_OKAY;
        end else begin
            ctrl_wr_pulse <= '0;
            if (s_axi.bvalid && s_axi.bready) s_axi.bvalid <= 1'b0;
            if (wr_fire) begin
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= wr_idx < NUM_RW ? RESP_OKAY : RESP_SLVERR;
                // an all-zero strobe is an accepted no-op: OKAY but no pulse
                for (int i = 0; i < NUM_RW; i++)
                    if (wr_idx == i && |wr_strb) begin
                        ctrl_q[i*DATA_W +: DATA_W] <= DATA_W'(strb_merge(64'(ctrl_q[i*DATA_W +: DATA_W]),
                                                                          64'(wr_data), 64'(wr_mask)));
                        ctrl_wr_pulse[i] <= 1'b1;
                    end
            end
        end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            status_rd_pulse <= '0;
            s_axi.rvalid    <= 1'b0;
            s_axi.rresp     <= RESP_OKAY;
            s_axi.rdata     <= '0;
        end else begin
            status_rd_pulse <= '0;
            if (s_axi.rvalid && s_axi.rready) s_axi.rvalid <= 1'b0;
            if (s_axi.arvalid && s_axi.arready) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rresp  <= rd_idx < NUM_RW + NUM_RO ? RESP_OKAY : RESP_SLVERR;
                s_axi.rdata  <= rd_val;
                for (int i = 0; i < NUM_RO; i++)
                    if (rd_idx == NUM_RW + i) status_rd_pulse[i] <= 1'b1;
            end
        end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: table-driven plus randomized self-checking bench for axil_reg_bank.
module tb_axil_reg_bank;
    import axil_pkg::*;

    localparam int DW = 32, AW = 6, NRW = 4, NRO = 2;

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
        logic [3:0]  pulse;
    } vec_t;

    logic tb_ACLK = 1'b0;
    logic tb_ARESETN = 1'b0;
    logic [NRW*DW-1:0] ctrl_q;
    logic [NRW-1:0]    ctrl_wr_pulse;
    logic [NRO*DW-1:0] status_d;
    logic [NRO-1:0]    status_rd_pulse;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] m_rw [NRW];
    vec_t vec [20];

    axil_reg_bank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axil_reg_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESETN(tb_ARESETN), .s_axi(bus),
        .ctrl_q(ctrl_q), .ctrl_wr_pulse(ctrl_wr_pulse),
        .status_d(status_d), .status_rd_pulse(status_rd_pulse)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NRW*DW-1:0] model_flat();
        logic [NRW*DW-1:0] f;
        for (int i = 0; i < NRW; i++) f[i*DW +: DW] = m_rw[i];
        return f;
    endfunction

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] pulse);
        bit aw_d = 0, w_d = 0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1;
        for (int c = 0; c < 20 && !(aw_d && w_d); c++) begin
            if (bus.awvalid && bus.awready) aw_d = 1;
            if (bus.wvalid && bus.wready) w_d = 1;
            @(negedge tb_ACLK);
            if (aw_d) bus.awvalid = 0;
            if (w_d) bus.wvalid = 0;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        check("wr_accepted", 64'(aw_d && w_d), 1);
        check("wr_bvalid_latency", 64'(bus.bvalid), 1);
        resp = bus.bresp;
        pulse = ctrl_wr_pulse;
        @(negedge tb_ACLK);
        check("wr_pulse_one_cycle", 64'(ctrl_wr_pulse), 0);
        check("wr_bvalid_cleared", 64'(bus.bvalid), 0);
    endtask

    task automatic do_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output logic [1:0] pulse);
        bit ok = 0;
        bus.araddr = a; bus.arvalid = 1; bus.rready = 1;
        for (int c = 0; c < 20 && !ok; c++) begin
            ok = bus.arready;
            @(negedge tb_ACLK);
        end
        bus.arvalid = 0;
        check("rd_accepted", 64'(ok), 1);
        check("rd_rvalid_latency", 64'(bus.rvalid), 1);
        d = bus.rdata; resp = bus.rresp; pulse = status_rd_pulse;
        @(negedge tb_ACLK);
        check("rd_pulse_one_cycle", 64'(status_rd_pulse), 0);
        check("rd_rvalid_cleared", 64'(bus.rvalid), 0);
    endtask

    initial begin
        logic [1:0] resp, sp;
        logic [3:0] wp;
        logic [31:0] rd;
        vec[0]  = '{1, 6'h00, 32'h0101FFFF, 4'hF, 32'h0, RESP_OKAY, 4'b0001};
        vec[1]  = '{1, 6'h04, 32'hABCD0001, 4'hF, 32'h0, RESP_OKAY, 4'b0010};
        vec[2]  = '{1, 6'h08, 32'hDEAD0011, 4'hF, 32'h0, RESP_OKAY, 4'b0100};
        vec[3]  = '{1, 6'h0C, 32'hBEEF0011, 4'hF, 32'h0, RESP_OKAY, 4'b1000};
        vec[4]  = '{0, 6'h00, 32'h0, 4'h0, 32'h0101FFFF, RESP_OKAY, 4'b0000};
        vec[5]  = '{0, 6'h04, 32'h0, 4'h0, 32'hABCD0001, RESP_OKAY, 4'b0000};
        vec[6]  = '{0, 6'h08, 32'h0, 4'h0, 32'hDEAD0011, RESP_OKAY, 4'b0000};
        vec[7]  = '{0, 6'h0C, 32'h0, 4'h0, 32'hBEEF0011, RESP_OKAY, 4'b0000};
        vec[8]  = '{1, 6'h00, 32'hFFFFFFFF, 4'hF, 32'h0, RESP_OKAY, 4'b0001};
        vec[9]  = '{1, 6'h00, 32'h12345678, 4'h5, 32'h0, RESP_OKAY, 4'b0001};
        vec[10] = '{0, 6'h00, 32'h0, 4'h0, 32'hFF34FF78, RESP_OKAY, 4'b0000};
        vec[11] = '{1, 6'h00, 32'h00000000, 4'h0, 32'h0, RESP_OKAY, 4'b0000};
        vec[12] = '{0, 6'h00, 32'h0, 4'h0, 32'hFF34FF78, RESP_OKAY, 4'b0000};
        vec[13] = '{0, 6'h10, 32'h0, 4'h0, 32'hCAFE0001, RESP_OKAY, 4'b0001};
        vec[14] = '{1, 6'h10, 32'h11111111, 4'hF, 32'h0, RESP_SLVERR, 4'b0000};
        vec[15] = '{0, 6'h10, 32'h0, 4'h0, 32'hCAFE0001, RESP_OKAY, 4'b0001};
        vec[16] = '{0, 6'h3C, 32'h0, 4'h0, 32'h00000000, RESP_SLVERR, 4'b0000};
        vec[17] = '{0, 6'h14, 32'h0, 4'h0, 32'h5A5A1234, RESP_OKAY, 4'b0010};
        vec[18] = '{1, 6'h18, 32'h22222222, 4'hF, 32'h0, RESP_SLVERR, 4'b0000};
        vec[19] = '{0, 6'h03, 32'h0, 4'h0, 32'hFF34FF78, RESP_OKAY, 4'b0000};

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;
        status_d = {32'h5A5A1234, 32'hCAFE0001};

        repeat (3) @(negedge tb_ACLK);
        check("rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 0);
        check("rst_valids", 64'({bus.bvalid, bus.rvalid}), 0);
        check("rst_resp_rdata", 64'({bus.bresp, bus.rresp, bus.rdata}), 0);
        check("rst_ctrl_q", 64'(ctrl_q), 0);
        check("rst_pulses", 64'({ctrl_wr_pulse, status_rd_pulse}), 0);
        tb_ARESETN = 1;
        @(negedge tb_ACLK);
        check("post_rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 3'b111);

        for (int i = 0; i < $size(vec); i++) begin
            if (vec[i].wr) begin
                do_write(vec[i].addr, vec[i].data, vec[i].strb, resp, wp);
                check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vec[i].resp));
                check($sformatf("vec%0d_wr_pulse", i), 64'(wp), 64'(vec[i].pulse));
            end else begin
                do_read(vec[i].addr, rd, resp, sp);
                check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vec[i].exp));
                check($sformatf("vec%0d_rresp", i), 64'(resp), 64'(vec[i].resp));
                check($sformatf("vec%0d_rd_pulse", i), 64'({2'b00, sp}), 64'(vec[i].pulse));
            end
        end
        m_rw[0] = 32'hFF34FF78; m_rw[1] = 32'hABCD0001; m_rw[2] = 32'hDEAD0011; m_rw[3] = 32'hBEEF0011;

        // AW five cycles ahead of W
        bus.bready = 0; bus.awaddr = 6'h08; bus.awvalid = 1;
        check("split_aw_ready", 64'(bus.awready), 1);
        @(negedge tb_ACLK);
        bus.awvalid = 0;
        repeat (5) begin
            check("split_aw_held", 64'({bus.awready, bus.bvalid}), 0);
            @(negedge tb_ACLK);
        end
        bus.wdata = 32'h13572468; bus.wstrb = 4'hF; bus.wvalid = 1;
        check("split_w_ready", 64'(bus.wready), 1);
        @(negedge tb_ACLK);
        bus.wvalid = 0; m_rw[2] = 32'h13572468;
        check("split_aw_bvalid", 64'(bus.bvalid), 1);
        check("split_aw_ctrl", 64'(ctrl_q[2*DW +: DW]), 64'(32'h13572468));
        check("split_aw_pulse", 64'(ctrl_wr_pulse), 4'b0100);
        bus.bready = 1;
        @(negedge tb_ACLK);
        bus.bready = 0;
        // W five cycles ahead of AW
        bus.wdata = 32'h24681357; bus.wvalid = 1;
        check("split_w_first_ready", 64'(bus.wready), 1);
        @(negedge tb_ACLK);
        bus.wvalid = 0;
        repeat (5) begin
            check("split_w_held", 64'({bus.wready, bus.bvalid}), 0);
            check("split_w_no_write", 64'(ctrl_q[3*DW +: DW]), 64'(32'hBEEF0011));
            @(negedge tb_ACLK);
        end
        bus.awaddr = 6'h0C; bus.awvalid = 1;
        @(negedge tb_ACLK);
        bus.awvalid = 0; m_rw[3] = 32'h24681357;
        check("split_w_bvalid", 64'(bus.bvalid), 1);
        check("split_w_ctrl", 64'(ctrl_q[3*DW +: DW]), 64'(32'h24681357));
        bus.bready = 1;
        @(negedge tb_ACLK);

        // B back-pressure with a competing write offered
        bus.bready = 0; bus.awaddr = 6'h04; bus.wdata = 32'h0F0F0F0F; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        @(negedge tb_ACLK);
        bus.awaddr = 6'h00; bus.wdata = 32'hDEADBEEF; m_rw[1] = 32'h0F0F0F0F;
        repeat (10) begin
            check("bp_b_hold", 64'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 5'b1_00_00);
            check("bp_b_ctrl", 64'(ctrl_q), 64'(model_flat()));
            @(negedge tb_ACLK);
        end
        bus.awvalid = 0; bus.wvalid = 0; bus.bready = 1;
        @(negedge tb_ACLK);
        check("bp_b_released", 64'(bus.bvalid), 0);

        // R back-pressure with a competing read offered
        bus.rready = 0; bus.araddr = 6'h04; bus.arvalid = 1;
        @(negedge tb_ACLK);
        bus.araddr = 6'h10;
        repeat (10) begin
            check("bp_r_hold", 64'({bus.rvalid, bus.rresp, bus.arready, status_rd_pulse}), 6'b1_00_0_00);
            check("bp_r_data", 64'(bus.rdata), 64'(32'h0F0F0F0F));
            @(negedge tb_ACLK);
        end
        bus.arvalid = 0; bus.rready = 1;
        @(negedge tb_ACLK);
        check("bp_r_released", 64'(bus.rvalid), 0);

        // read and write of the same register in one cycle
        bus.awaddr = 6'h08; bus.wdata = 32'hABABABAB; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.bready = 1; bus.araddr = 6'h08; bus.arvalid = 1;
        @(negedge tb_ACLK);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        check("rw_same_rdata_old", 64'(bus.rdata), 64'(32'h13572468));
        check("rw_same_ctrl_new", 64'(ctrl_q[2*DW +: DW]), 64'(32'hABABABAB));
        m_rw[2] = 32'hABABABAB;
        @(negedge tb_ACLK);

        // reset while a response is pending
        bus.bready = 0; bus.awaddr = 6'h04; bus.wdata = 32'hABCD0001; bus.awvalid = 1; bus.wvalid = 1;
        @(negedge tb_ACLK);
        bus.awvalid = 0; bus.wvalid = 0;
        check("mid_rst_pre_bvalid", 64'(bus.bvalid), 1);
        check("mid_rst_pre_reg1", 64'(ctrl_q[DW +: DW]), 64'(32'hABCD0001));
        #2 tb_ARESETN = 0;
        #1;
        check("mid_rst_bvalid_async", 64'(bus.bvalid), 0);
        check("mid_rst_ctrl_reset", 64'(ctrl_q), 0);
        @(negedge tb_ACLK);
        tb_ARESETN = 1;
        for (int i = 0; i < NRW; i++) m_rw[i] = '0;
        @(negedge tb_ACLK);
        do_write(6'h04, 32'h600D600D, 4'hF, resp, wp);
        check("post_rst_bresp", 64'(resp), 64'(RESP_OKAY));
        check("post_rst_pulse", 64'(wp), 4'b0010);
        m_rw[1] = 32'h600D600D;
        do_read(6'h04, rd, resp, sp);
        check("post_rst_rdata", 64'(rd), 64'(32'h600D600D));

        // randomized traffic against a register-map model
        for (int n = 0; n < 300; n++) begin
            logic [5:0] a;
            logic [31:0] d;
            logic [3:0] s;
            int idx;
            a = 6'($urandom_range(0, 63));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            idx = int'(a) / 4;
            status_d = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, resp, wp);
                check("rnd_bresp", 64'(resp), 64'(idx < NRW ? RESP_OKAY : RESP_SLVERR));
                check("rnd_wr_pulse", 64'(wp), 64'((idx < NRW && s != 0) ? (1 << idx) : 0));
                if (idx < NRW)
                    for (int b = 0; b < 4; b++) if (s[b]) m_rw[idx][8*b +: 8] = d[8*b +: 8];
                check("rnd_ctrl_q", 64'(ctrl_q[63:0]), 64'(model_flat() >> 0));
                check("rnd_ctrl_q_hi", 64'(ctrl_q[127:64]), 64'(model_flat() >> 64));
            end else begin
                do_read(a, rd, resp, sp);
                if (idx < NRW) begin
                    check("rnd_rdata_rw", 64'(rd), 64'(m_rw[idx]));
                    check("rnd_rresp", 64'({resp, sp}), 64'({RESP_OKAY, 2'b00}));
                end else if (idx < NRW + NRO) begin
                    check("rnd_rdata_ro", 64'(rd), 64'(status_d[(idx-NRW)*DW +: DW]));
                    check("rnd_rresp", 64'({resp, sp}), 64'({RESP_OKAY, 2'(1 << (idx-NRW))}));
                end else begin
                    check("rnd_rdata_unmapped", 64'(rd), 0);
                    check("rnd_rresp", 64'({resp, sp}), 64'({RESP_SLVERR, 2'b00}));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axil_reg_bank.md
Name: axil_reg_bank

Overview:
- Parametrised AXI4-Lite slave register bank; the next generation of the fixed four-register slave in our I2C IP.
- Provides NUM_RW read/write control registers and NUM_RO read-only status registers.
- Supports byte strobes, independent AW/W acceptance, back-pressure on B/R, and SLVERR on illegal accesses.
- Sits between the AXI interconnect and the I2C core (or any future peripheral core) as its register front-end.

Parameters:
- DATA_W, 32, AXI data width; 32 or 64 only.
- ADDR_W, 6, AXI address width; must satisfy 2^ADDR_W >= (NUM_RW+NUM_RO)*DATA_W/8.
- NUM_RW, 4, number of read/write registers, 1..16.
- NUM_RO, 2, number of read-only status registers, 0..16.
- RW_RESET, 0, common reset value of all RW registers, DATA_W bits.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  DATA_W  write data.
- S_AXI_WSTRB  in  DATA_W/8  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  DATA_W  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read valid.
- S_AXI_RREADY  in  1  read ready.
- ctrl_q  out  NUM_RW*DATA_W  flattened RW register contents; register i at [i*DATA_W +: DATA_W].
- ctrl_wr_pulse  out  NUM_RW  one-cycle pulse per RW register written with at least one strobe set.
- status_d  in  max(NUM_RO,1)*DATA_W  flattened status inputs, synchronous to S_AXI_ACLK.
- status_rd_pulse  out  max(NUM_RO,1)  one-cycle pulse when an RO register is read, usable for clear-on-read in the core.

Behaviour:
- One clock, S_AXI_ACLK. S_AXI_ARESETN is asynchronous active-low; assertion immediately forces all state to reset values. Deassertion is synchronised externally.
- Reset values:
  - All READY, VALID and pulse outputs are 0; RESP outputs are 0; RDATA is 0.
  - ctrl_q is RW_RESET for every register.
  - AW and W holding registers are empty.
- Register index = ADDR[ADDR_W-1:ADDR_LSB], where ADDR_LSB = log2(DATA_W/8); the low address bits are ignored.
  - index < NUM_RW: RW register.
  - NUM_RW <= index < NUM_RW+NUM_RO: RO register.
  - Any other index: unmapped.
- Write path:
  - AWREADY = 1 when the AW holder is empty and BVALID = 0.
  - WREADY = 1 when the W holder is empty and BVALID = 0.
  - AW and W are accepted independently and in either order; each is captured on its own handshake.
  - In the first cycle both holders are full (or the same cycle both handshake together), the write executes at the next edge. At that edge: the holders clear, BVALID rises, and the addressed ctrl_wr_pulse bit is 1 for exactly that cycle.
  - Latency: AW and W together in cycle N gives ctrl_q updated and BVALID = 1 in cycle N+1.
  - Byte lane k is updated only if WSTRB[k] = 1. If all strobes are 0, nothing is written, no pulse is generated, and BRESP = OKAY.
  - Write to an RO or unmapped index: no state change, no pulse, BRESP = 2'b10 (SLVERR).
  - BVALID and BRESP hold until BREADY = 1. The handshake clears BVALID. No new AW or W is accepted while BVALID = 1, so at most one write is outstanding.
- Read path:
  - ARREADY = 1 when RVALID = 0.
  - On an AR handshake in cycle N: RDATA, RRESP and RVALID are registered and valid in N+1. status_d is sampled in cycle N.
  - status_rd_pulse for the addressed RO register is 1 in cycle N+1 only.
  - Unmapped index: RDATA = 0, RRESP = SLVERR, no pulse.
  - RDATA, RRESP and RVALID hold until RREADY = 1.
- Simultaneous read and write to the same RW register in one cycle: the read returns the pre-write value. Reads and writes are fully independent.
- Reset asserted mid-transaction: the transaction is dropped and all VALIDs fall immediately. The master is not required to see any response.

Decomposition:
- Shared package axil_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Function clog2.
  - Function for the byte-strobe merge, new = (old & ~mask) | (wdata & mask).
- One sub-module, axil_wr_capture: the AW/W holding registers plus their ready logic, producing a single "write fire" strobe with latched addr, data and strobe. The read path stays inline.

Test Plan:
- Defaults; write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to 0x00, 0x04, 0x08, 0x0C; read each back -> identical data, RRESP = 0, BRESP = 0, one ctrl_wr_pulse per write.
- AW sent 5 cycles before W, then the reverse order -> write executes 1 cycle after the later handshake; AWREADY stays low between the two while its holder is full.
- Reg0 = 0xFFFFFFFF, then write 0x12345678 with WSTRB = 4'b0101 -> reg0 reads 0xFF34FF78. WSTRB = 0 -> reg0 unchanged, BRESP = OKAY, no pulse.
- status_d[0] = 0xCAFE0001; read 0x10 -> 0xCAFE0001 with status_rd_pulse[0] = 1 for one cycle. Write 0x10 -> SLVERR, read-back unchanged. Read 0x3C -> 0x00000000, SLVERR.
- BREADY and RREADY held low 10 cycles -> BVALID/RVALID, data and resp stable throughout; no further AW/W/AR accepted until the handshake completes.
- Reset pulsed low while BVALID = 1 and reg1 = 0xABCD0001 -> BVALID = 0 immediately; reg1 returns to RW_RESET; the next write completes normally.
